// File: rtl/rsa_xcel_client_pkg.sv
// Shared xcel message formats and accelerator register map for the
// stream-to-xcel client.
package rsa_xcel_client_pkg;

    localparam logic VC_XCEL_REQ_READ   = 1'b0;
    localparam logic VC_XCEL_REQ_WRITE  = 1'b1;
    localparam logic VC_XCEL_RESP_READ  = 1'b0;
    localparam logic VC_XCEL_RESP_WRITE = 1'b1;

    localparam logic [4:0] XR_GO   = 5'd0;
    localparam logic [4:0] XR_BASE = 5'd1;
    localparam logic [4:0] XR_EXP  = 5'd2;
    localparam logic [4:0] XR_MOD  = 5'd3;

    typedef struct packed {
        logic        type_;
        logic [4:0]  addr;
        logic [31:0] data;
    } xcel_req_t;

    typedef struct packed {
        logic        type_;
        logic [31:0] data;
    } xcel_resp_t;

endpackage

// File: rtl/rsa_xcel_client_if.sv
// Operand/result streams and xcel request/response streams of the client.
// master = the client, slave = producer/consumer/accelerator side.
interface rsa_xcel_client_if;

    logic [95:0]                     istream_msg;
    logic                            istream_val;
    logic                            istream_rdy;
    logic [31:0]                     ostream_msg;
    logic                            ostream_val;
    logic                            ostream_rdy;
    rsa_xcel_client_pkg::xcel_req_t  xcel_reqstream_msg;
    logic                            xcel_reqstream_val;
    logic                            xcel_reqstream_rdy;
    rsa_xcel_client_pkg::xcel_resp_t xcel_respstream_msg;
    logic                            xcel_respstream_val;
    logic                            xcel_respstream_rdy;
    logic                            resp_err;

    modport master (
        input  istream_msg, istream_val, output istream_rdy,
        output ostream_msg, ostream_val, input  ostream_rdy,
        output xcel_reqstream_msg, xcel_reqstream_val, input xcel_reqstream_rdy,
        input  xcel_respstream_msg, xcel_respstream_val, output xcel_respstream_rdy,
        output resp_err
    );

    modport slave (
        output istream_msg, istream_val, input  istream_rdy,
        input  ostream_msg, ostream_val, output ostream_rdy,
        input  xcel_reqstream_msg, xcel_reqstream_val, output xcel_reqstream_rdy,
        output xcel_respstream_msg, xcel_respstream_val, input xcel_respstream_rdy,
        input  resp_err
    );

endinterface

// File: rtl/rsa_xcel_client.sv
// Drives one modexp operation through the xcel register protocol:
// write base/exp/mod, write go, read go, then return the read data.
module rsa_xcel_client
    import rsa_xcel_client_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    rsa_xcel_client_if.master bus
);

    typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;

    state_t      state, state_n;
    logic [2:0]  step, step_n;
    logic [95:0] operand, operand_n;
    logic [31:0] result, result_n;
    logic        resp_err_q, resp_err_n;

    logic        istream_rdy, req_val, resp_rdy, out_val;
    logic        exp_type;
    xcel_req_t   req;
    xcel_resp_t  resp;

    assign resp = bus.xcel_respstream_msg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            step       <= 3'd0;
            operand    <= '0;
            result     <= '0;
            resp_err_q <= 1'b0;
        end else begin
            state      <= state_n;
            step       <= step_n;
            operand    <= operand_n;
            result     <= result_n;
            resp_err_q <= resp_err_n;
        end
    end

    always_comb begin
        state_n     = state;
        step_n      = step;
        operand_n   = operand;
        result_n    = result;
        resp_err_n  = resp_err_q;
        istream_rdy = 1'b0;
        req_val     = 1'b0;
        resp_rdy    = 1'b0;
        out_val     = 1'b0;
        // only the final go-register read expects a READ response
        exp_type    = (step == 3'd4) ? VC_XCEL_RESP_READ : VC_XCEL_RESP_WRITE;
        case (state)
            IDLE: begin
                istream_rdy = 1'b1;
                if (bus.istream_val) begin
                    operand_n  = bus.istream_msg;
                    step_n     = 3'd0;
                    resp_err_n = 1'b0;
                    state_n    = SEND;
                end
            end
            SEND: begin
                req_val = 1'b1;
                if (bus.xcel_reqstream_rdy) state_n = WAIT;
            end
            WAIT: begin
                resp_rdy = 1'b1;
                if (bus.xcel_respstream_val) begin
                    if (resp.type_ != exp_type) resp_err_n = 1'b1;
                    if (step == 3'd4) begin
                        result_n = resp.data;
                        state_n  = DONE;
                    end else begin
                        step_n  = step + 3'd1;
                        state_n = SEND;
                    end
                end
            end
            DONE: begin
                out_val = 1'b1;
                if (bus.ostream_rdy) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        req = '0;
        case (step)
            3'd0:    req = '{VC_XCEL_REQ_WRITE, XR_BASE, operand[31:0]};
            3'd1:    req = '{VC_XCEL_REQ_WRITE, XR_EXP,  operand[63:32]};
            3'd2:    req = '{VC_XCEL_REQ_WRITE, XR_MOD,  operand[95:64]};
            3'd3:    req = '{VC_XCEL_REQ_WRITE, XR_GO,   32'd0};
            3'd4:    req = '{VC_XCEL_REQ_READ,  XR_GO,   32'd0};
            default: req = '0;
        endcase
    end

    assign bus.istream_rdy         = istream_rdy;
    assign bus.xcel_reqstream_val  = req_val;
    assign bus.xcel_reqstream_msg  = xcel_req_t'(req & {$bits(xcel_req_t){req_val}});
    assign bus.xcel_respstream_rdy = resp_rdy;
    assign bus.ostream_val         = out_val;
    assign bus.ostream_msg         = result & {32{out_val}};
    assign bus.resp_err            = resp_err_q;

endmodule

// File: tb/tb_rsa_xcel_client.sv
// Directed bench for rsa_xcel_client: a lockstep accelerator model answers
// each request; table rows cover stalls, slow compute, errors and reset.
module tb_rsa_xcel_client;
    import rsa_xcel_client_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    rsa_xcel_client_if bus();

    rsa_xcel_client dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [31:0] xr [0:3];

    typedef struct {
        logic [31:0] b, e, m;
        int          req_stall, read_delay, err_step, out_stall;
        bit          spurious;
        logic [31:0] res;
        logic        err;
        int          lat;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] modexp(input logic [31:0] b, e, m);
        logic [63:0] r, bb;
        if (m == 0) return 32'd0;
        r  = 64'd1 % m;
        bb = b % m;
        for (int i = 0; i < 32; i++) begin
            if (e[i]) r = (r * bb) % m;
            bb = (bb * bb) % m;
        end
        return r[31:0];
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_istream_rdy"}, bus.istream_rdy, 1);
        chk({tag, "_req_val"}, bus.xcel_reqstream_val, 0);
        chk({tag, "_req_msg"}, bus.xcel_reqstream_msg, 0);
        chk({tag, "_resp_rdy"}, bus.xcel_respstream_rdy, 0);
        chk({tag, "_ostream_val"}, bus.ostream_val, 0);
        chk({tag, "_ostream_msg"}, bus.ostream_msg, 0);
        chk({tag, "_resp_err"}, bus.resp_err, 0);
    endtask

    task automatic run_op(input vec_t v, input int abort_step);
        logic [37:0] exp_req [0:4];
        logic [37:0] rq;
        logic        rtype;
        int          lat;
        exp_req[0] = {1'b1, 5'd1, v.b};
        exp_req[1] = {1'b1, 5'd2, v.e};
        exp_req[2] = {1'b1, 5'd3, v.m};
        exp_req[3] = {1'b1, 5'd0, 32'd0};
        exp_req[4] = {1'b0, 5'd0, 32'd0};

        chk("istream_rdy_idle", bus.istream_rdy, 1);
        bus.istream_msg = {v.m, v.e, v.b};
        bus.istream_val = 1'b1;
        tick;
        bus.istream_val = 1'b0;
        bus.istream_msg = '0;
        lat = 1;

        for (int s = 0; s < 5; s++) begin
            if (s == abort_step) begin
                chk("resp_err_pre_reset", bus.resp_err, (v.err_step >= 0 && v.err_step < s));
                reset = 1'b1;
                tick;
                reset = 1'b0;
                chk_reset_outputs("abort");
                return;
            end
            for (int k = 0; k < v.req_stall; k++) begin
                if (v.spurious && s == 4) begin
                    bus.xcel_respstream_val = 1'b1;
                    bus.xcel_respstream_msg = {1'b0, 32'hdead_beef};
                end
                chk("req_val_stall", bus.xcel_reqstream_val, 1);
                chk("req_msg_stable", bus.xcel_reqstream_msg, exp_req[s]);
                chk("resp_rdy_send", bus.xcel_respstream_rdy, 0);
                chk("istream_rdy_busy", bus.istream_rdy, 0);
                tick;
                lat++;
            end
            bus.xcel_respstream_val = 1'b0;
            bus.xcel_respstream_msg = '0;
            rq = bus.xcel_reqstream_msg;
            chk("req_val", bus.xcel_reqstream_val, 1);
            chk("req_msg", rq, exp_req[s]);
            if (rq[37]) xr[rq[33:32]] = rq[31:0];
            bus.xcel_reqstream_rdy = 1'b1;
            tick;
            lat++;
            bus.xcel_reqstream_rdy = 1'b0;
            chk("req_no_dup", bus.xcel_reqstream_val, 0);
            if (s == 4) begin
                for (int k = 0; k < v.read_delay; k++) begin
                    chk("resp_rdy_hold", bus.xcel_respstream_rdy, 1);
                    chk("ostream_val_early", bus.ostream_val, 0);
                    chk("ostream_msg_masked", bus.ostream_msg, 0);
                    chk("istream_rdy_compute", bus.istream_rdy, 0);
                    tick;
                    lat++;
                end
            end
            rtype = (s == 4) ? 1'b0 : 1'b1;
            if (s == v.err_step) rtype = ~rtype;
            bus.xcel_respstream_msg = {rtype, (s == 4) ? modexp(xr[1], xr[2], xr[3]) : 32'd0};
            bus.xcel_respstream_val = 1'b1;
            chk("resp_rdy_wait", bus.xcel_respstream_rdy, 1);
            tick;
            lat++;
            bus.xcel_respstream_val = 1'b0;
            bus.xcel_respstream_msg = '0;
        end

        chk("latency", lat, v.lat);
        chk("ostream_val", bus.ostream_val, 1);
        chk("ostream_msg", bus.ostream_msg, v.res);
        chk("resp_err", bus.resp_err, v.err);
        for (int k = 0; k < v.out_stall; k++) begin
            bus.istream_val = 1'b1;
            bus.istream_msg = {32'd5, 32'd1, 32'd2};
            chk("ostream_val_hold", bus.ostream_val, 1);
            chk("ostream_msg_hold", bus.ostream_msg, v.res);
            chk("istream_rdy_done", bus.istream_rdy, 0);
            tick;
        end
        bus.ostream_rdy = 1'b1;
        tick;
        bus.ostream_rdy = 1'b0;
        chk("ostream_val_drop", bus.ostream_val, 0);
        chk("istream_rdy_back", bus.istream_rdy, 1);
        chk("no_accept_in_done", bus.xcel_reqstream_val, 0);
        bus.istream_val = 1'b0;
        bus.istream_msg = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [7];
        bus.istream_msg         = '0;
        bus.istream_val         = 1'b0;
        bus.ostream_rdy         = 1'b0;
        bus.xcel_reqstream_rdy  = 1'b0;
        bus.xcel_respstream_msg = '0;
        bus.xcel_respstream_val = 1'b0;
        for (int i = 0; i < 4; i++) xr[i] = '0;

        reset = 1'b1;
        tick;
        tick;
        chk_reset_outputs("reset");
        reset = 1'b0;

        //           b  e   m     rstall rdly err ostall spur  res   err lat
        tbl[0] = '{4, 13, 497,  0, 0,  -1, 0, 1'b0, 445, 1'b0, 11};
        tbl[1] = '{4, 13, 497,  3, 0,  -1, 0, 1'b0, 445, 1'b0, 26};
        tbl[2] = '{4, 13, 497,  2, 40, -1, 0, 1'b1, 445, 1'b0, 61};
        tbl[3] = '{4, 13, 497,  0, 0,  -1, 5, 1'b0, 445, 1'b0, 11};
        tbl[4] = '{2, 10, 1000, 0, 0,  -1, 0, 1'b0, 24,  1'b0, 11};
        tbl[5] = '{3, 0,  7,    0, 0,  -1, 0, 1'b0, 1,   1'b0, 11};
        tbl[6] = '{4, 13, 497,  0, 0,  1,  0, 1'b0, 445, 1'b1, 11};

        for (int i = 0; i < 7; i++) run_op(tbl[i], -1);

        // reset during step 3 of an operation that already flagged an error
        run_op(tbl[6], 3);
        run_op(tbl[0], -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rsa_xcel_client.md
Name: rsa_xcel_client

Overview:
Host-side initiator for the modular-exponentiation accelerator register protocol. It accepts a {modulus, exponent, base} operand bundle on a latency-insensitive istream. It then drives the five-step xcel request sequence: write xr1/xr2/xr3, write xr0 (go), read xr0. It returns the read data on a 32-bit ostream. It lets stream-style producers, such as test sources and the RSA block engine, use any accelerator that speaks the xcel register interface without a processor in the loop.

Parameters:
None. Widths are fixed by the xcel message format: req = {type_ 1b, addr 5b, data 32b}; resp = {type_ 1b, data 32b}.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
istream_msg  in  96  [31:0] base, [63:32] exponent, [95:64] modulus
istream_val  in  1  operand valid
istream_rdy  out  1  client can accept operands
ostream_msg  out  32  modexp result
ostream_val  out  1  result valid
ostream_rdy  in  1  consumer ready
xcel_reqstream_msg  out  38  xcel_req_t
xcel_reqstream_val  out  1  request valid
xcel_reqstream_rdy  in  1  accelerator accepts request
xcel_respstream_msg  in  33  xcel_resp_t
xcel_respstream_val  in  1  response valid
xcel_respstream_rdy  out  1  client accepts response
resp_err  out  1  sticky flag: response type mismatch seen in the current operation

Behaviour:
- Interface: reset is synchronous and active-high; clock is clk.
- State: IDLE, SEND, WAIT, DONE. There is a 3-bit step counter, 0..4.
- Reset: state=IDLE, step=0, operand regs=0, result=0, resp_err=0.
  - Outputs after reset: istream_rdy=1; all other valids=0; all msgs=0.
- IDLE:
  - istream_rdy=1.
  - On istream_val, latch the 96-bit operand, set step=0, clear resp_err, and go to SEND.
- SEND:
  - xcel_reqstream_val=1. The message depends on step:
    - step 0: (WRITE, addr 1, base)
    - step 1: (WRITE, addr 2, exp)
    - step 2: (WRITE, addr 3, mod)
    - step 3: (WRITE, addr 0, 0)
    - step 4: (READ, addr 0, 0)
  - On xcel_reqstream_rdy, go to WAIT.
  - The message must stay stable while val=1 and rdy=0.
- WAIT:
  - xcel_respstream_rdy=1.
  - On xcel_respstream_val:
    - Expected type is WRITE for steps 0-3 and READ for step 4. A mismatch sets resp_err; the sequence continues regardless.
    - If step<4: step++, go to SEND.
    - If step=4: result<=resp.data, go to DONE.
- DONE:
  - ostream_val=1, ostream_msg=result.
  - On ostream_rdy, go to IDLE.
  - istream_rdy stays 0 until IDLE is re-entered, so there is no bubble-free overlap.
- Outstanding requests: exactly one at a time. No new request is issued until the previous response is consumed.
- Response outside WAIT: xcel_respstream_rdy=0, so the response is held off and never dropped.
- Latency: with a responder that accepts and answers one cycle after the request:
  - each step takes 2 cycles;
  - ostream_val asserts 11 cycles after the istream handshake cycle.
  - Accelerator compute time stretches the step-4 response wait.
- 4-state hygiene: xcel_reqstream_msg is ANDed with {38{val}}; ostream_msg is ANDed with {32{val}}.
- Reset mid-operation:
  - returns to IDLE immediately; any in-flight request or result is abandoned;
  - resp_err is cleared;
  - the accelerator side is expected to be reset by the same signal.
- Simultaneous ostream_rdy and istream_val in DONE: istream is not accepted that cycle. It is accepted in the following IDLE cycle.

Decomposition:
- Shared package: xcel_req_t/xcel_resp_t, VC_XCEL_REQ/RESP type constants, and register index localparams (XR_GO=0, XR_BASE=1, XR_EXP=2, XR_MOD=3).
- State encodings are local.
- No sub-module: single FSM plus datapath, about 150-200 lines.

Test Plan:
- Basic: istream (base 4, exp 13, mod 497) against a responder model.
  - Request order must be exactly (W,1,4), (W,2,13), (W,3,497), (W,0,0), (R,0,0).
  - ostream returns 445; resp_err=0; latency is 11 cycles with a 1-cycle responder.
- Request backpressure: hold xcel_reqstream_rdy=0 for 3 cycles at each step. The message must be stable, no request may be duplicated, and the result must be unchanged (445).
- Slow compute: delay the READ response 40 cycles and inject a spurious resp_val before the READ request. The response must not be consumed outside WAIT, ostream must be correct, and istream_rdy must stay 0 throughout.
- Result backpressure: ostream_rdy=0 for 5 cycles. ostream_val and msg must hold, and istream_rdy must be 0 until the handshake.
- Back-to-back: operations (2,10,1000) then (3,0,7) must give 24 then 1, with resp_err=0 each.
- Errors:
  - The responder returns READ type for step 1. resp_err must go to 1 and the sequence must complete.
  - Assert reset during step 3. All outputs must go to their reset values the next cycle, and a fresh operation must succeed.
